uart_tx: RTL and testbench

- UART transmitter; serialises one parallel word per frame onto tx_pin.
- Frame format: start bit, DATA_BITS data bits LSB first, optional odd-parity bit, stop bit.
- Bit timing derives from the shared tick_16x oversample strobe, so line timing matches uart_rx on the same tick source.
- Sits between a byte producer (valid/ready handshake) and the serial pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, default frame parameters and the odd-parity helper.
package uart_pkg;

   localparam int unsigned DEFAULT_DATA_BITS  = 8;
   localparam int unsigned DEFAULT_OVS_FACTOR = 16;
   localparam int unsigned MAX_DATA_BITS      = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

   // Zero-extended input keeps the XOR unchanged for any DATA_BITS up to MAX_DATA_BITS.
   function automatic logic odd_parity(input logic [MAX_DATA_BITS-1:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_if #(
   parameter int unsigned DATA_BITS = 8
);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 parity_enable;

   modport master (
      output tx_data,
      output tx_valid,
      output parity_enable,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  parity_enable,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS data LSB first, optional odd parity, stop; timed by tick_16x.
// Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned OVS_FACTOR = DEFAULT_OVS_FACTOR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_16x,
   uart_tx_if.slave   bus,
   output logic       tx_pin,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned OS_W = $clog2(OVS_FACTOR);
   localparam int unsigned BI_W = $clog2(DATA_BITS);

   uart_tx_state_e       state_q, state_d;
   logic [OS_W-1:0]      os_count_q, os_count_d;
   logic [BI_W-1:0]      bit_index_q, bit_index_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_en_q, par_en_d;
   logic                 parity_q, parity_d;
   logic                 tx_ready_q;
   logic                 pin_d;
   logic                 done_d;
   logic                 bit_end;
`ifdef UART_TX_TWO_STOP_EN
   logic                 stop_sel_q, stop_sel_d;
`endif

   assign bus.tx_ready = tx_ready_q;

   // Next-state, counters and the registered line level for the coming cycle.
   always_comb begin
      state_d     = state_q;
      os_count_d  = os_count_q;
      bit_index_d = bit_index_q;
      shift_d     = shift_q;
      par_en_d    = par_en_q;
      parity_d    = parity_q;
      done_d      = 1'b0;
      bit_end     = 1'b0;
      pin_d       = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
      stop_sel_d  = stop_sel_q;
`endif

      if (state_q != IDLE && tick_16x) begin
         if (os_count_q == OS_W'(OVS_FACTOR - 1)) begin
            os_count_d = '0;
            bit_end    = 1'b1;
         end else begin
            os_count_d = os_count_q + OS_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.tx_valid && tx_ready_q) begin
               shift_d    = bus.tx_data;
               par_en_d   = bus.parity_enable;
               parity_d   = odd_parity(MAX_DATA_BITS'(bus.tx_data));
               os_count_d = '0;
               state_d    = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d     = DATA;
               bit_index_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_index_q == BI_W'(DATA_BITS - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_index_d = bit_index_q + BI_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
`ifdef UART_TX_TWO_STOP_EN
            if (bit_end) begin
               if (!stop_sel_q) begin
                  stop_sel_d = 1'b1;
               end else begin
                  stop_sel_d = 1'b0;
                  state_d    = IDLE;
                  done_d     = 1'b1;
               end
            end
`else
            if (bit_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered so tx_pin comes straight from a flop.
      case (state_d)
         START:   pin_d = 1'b0;
         DATA:    pin_d = shift_d[bit_index_d];
         PARITY:  pin_d = parity_d;
         default: pin_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         os_count_q  <= '0;
         bit_index_q <= '0;
         shift_q     <= '0;
         par_en_q    <= 1'b0;
         parity_q    <= 1'b0;
         tx_pin      <= 1'b1;
         tx_ready_q  <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_sel_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         os_count_q  <= os_count_d;
         bit_index_q <= bit_index_d;
         shift_q     <= shift_d;
         par_en_q    <= par_en_d;
         parity_q    <= parity_d;
         tx_pin      <= pin_d;
         tx_ready_q  <= (state_d == IDLE);
         tx_busy     <= (state_d != IDLE);
         tx_done     <= done_d;
`ifdef UART_TX_TWO_STOP_EN
         stop_sel_q  <= stop_sel_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-tick line checks, frame length, back-to-back and reset abort.
module tb_uart_tx;

   localparam int unsigned DB  = 8;
   localparam int unsigned OVS = 16;
`ifdef UART_TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic tick_16x = 1'b0;
   logic tx_pin;
   logic tx_busy;
   logic tx_done;
   bit [1:0] div = 2'd0;

   int checks   = 0;
   int failures = 0;

   uart_tx_if #(.DATA_BITS(DB)) bus ();

   uart_tx #(
      .DATA_BITS (DB),
      .OVS_FACTOR(OVS)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tick_16x(tick_16x),
      .bus     (bus.slave),
      .tx_pin  (tx_pin),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   // One tick every 4 clocks, updated just after the edge so it is stable when sampled.
   always @(posedge clk) begin
      #1;
      tick_16x = (div == 2'd3);
      div      = div + 2'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic par, input logic pbit);
      logic [15:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
      if (par) b[9] = pbit;
      return b;
   endfunction

   function automatic int frame_len(input logic par);
      return 9 + (par ? 1 : 0) + NSTOP;
   endfunction

   // Present a word at a negedge; returns at the negedge right after the accept edge.
   task automatic start_frame(input string tag, input logic [7:0] d, input logic par, input bit align);
      @(negedge clk);
      for (int i = 0; i < 2000 && !bus.tx_ready; i++) @(negedge clk);
      if (!bus.tx_ready) check({tag, "_ready_timeout"}, 32'(bus.tx_ready), 32'd1);
      if (align) begin
         for (int i = 0; i < 8 && !tick_16x; i++) @(negedge clk);
      end
      bus.tx_data       = d;
      bus.parity_enable = par;
      bus.tx_valid      = 1'b1;
      @(negedge clk);
      bus.tx_valid      = 1'b0;
      bus.tx_data       = ~d;
      bus.parity_enable = ~par;
      check({tag, "_start_pin"}, 32'(tx_pin), 32'd0);
      check({tag, "_start_busy"}, 32'(tx_busy), 32'd1);
      check({tag, "_start_ready"}, 32'(bus.tx_ready), 32'd0);
   endtask

   // Walk the frame tick by tick from the start bit; returns at the negedge where tx_done is seen.
   task automatic track_frame(input string tag, input logic [15:0] bits, input int nbits);
      int  t;
      bit  done_seen;
      logic expb;
      t         = 0;
      done_seen = 1'b0;
      for (int cyc = 0; cyc < nbits * OVS * 4 + 50 && !done_seen; cyc++) begin
         if (tx_done) begin
            done_seen = 1'b1;
            check({tag, "_ticks"}, 32'(t), 32'(nbits * OVS));
            check({tag, "_end_ready"}, 32'(bus.tx_ready), 32'd1);
            check({tag, "_end_pin"}, 32'(tx_pin), 32'd1);
         end else begin
            if (tick_16x) begin
               expb = (t / OVS < nbits) ? bits[t / OVS] : 1'b1;
               check({tag, "_pin"}, 32'(tx_pin), 32'(expb));
               t++;
            end
            @(negedge clk);
         end
      end
      if (!done_seen) check({tag, "_done_timeout"}, 32'(done_seen), 32'd1);
   endtask

   initial begin
      int t;
      int done_cnt;

      bus.tx_valid      = 1'b0;
      bus.tx_data       = '0;
      bus.parity_enable = 1'b0;
      reset             = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pin", 32'(tx_pin), 32'd1);
      check("rst_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      reset = 1'b0;

      // A5, no parity, accepted on a tick cycle; tx_data/parity change mid-frame.
      start_frame("a5", 8'hA5, 1'b0, 1'b1);
      track_frame("a5", frame_bits(8'hA5, 1'b0, 1'b0), frame_len(1'b0));
      @(negedge clk);
      check("a5_done_pulse", 32'(tx_done), 32'd0);

      start_frame("p03", 8'h03, 1'b1, 1'b0);
      track_frame("p03", frame_bits(8'h03, 1'b1, 1'b1), frame_len(1'b1));

      start_frame("p07", 8'h07, 1'b1, 1'b1);
      track_frame("p07", frame_bits(8'h07, 1'b1, 1'b0), frame_len(1'b1));

      start_frame("z00", 8'h00, 1'b0, 1'b0);
      track_frame("z00", frame_bits(8'h00, 1'b0, 1'b0), frame_len(1'b0));

      // Back-to-back with tx_valid held high throughout.
      @(negedge clk);
      bus.tx_data       = 8'h55;
      bus.parity_enable = 1'b0;
      bus.tx_valid      = 1'b1;
      @(negedge clk);
      check("b55_start_pin", 32'(tx_pin), 32'd0);
      check("b55_start_busy", 32'(tx_busy), 32'd1);
      track_frame("b55", frame_bits(8'h55, 1'b0, 1'b0), frame_len(1'b0));
      bus.tx_data = 8'hAA;
      @(negedge clk);
      check("baa_start_pin", 32'(tx_pin), 32'd0);
      check("baa_start_busy", 32'(tx_busy), 32'd1);
      check("baa_start_ready", 32'(bus.tx_ready), 32'd0);
      check("baa_done_pulse", 32'(tx_done), 32'd0);
      bus.tx_valid = 1'b0;
      track_frame("baa", frame_bits(8'hAA, 1'b0, 1'b0), frame_len(1'b0));
      @(negedge clk);
      check("baa_no_dup", 32'(tx_busy), 32'd0);

      // Reset in the middle of data bit 3 (frame bit 4).
      start_frame("rf0", 8'hF0, 1'b0, 1'b0);
      t = 0;
      for (int c = 0; c < 1000 && t < 4 * OVS + 8; c++) begin
         if (tick_16x) t++;
         @(negedge clk);
      end
      check("rf0_bit3_pin", 32'(tx_pin), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rf0_abort_pin", 32'(tx_pin), 32'd1);
      check("rf0_abort_ready", 32'(bus.tx_ready), 32'd1);
      check("rf0_abort_busy", 32'(tx_busy), 32'd0);
      check("rf0_abort_done", 32'(tx_done), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 800; c++) begin
         if (tx_done) done_cnt++;
         @(negedge clk);
      end
      check("rf0_no_done", 32'(done_cnt), 32'd0);

      start_frame("r81", 8'h81, 1'b0, 1'b0);
      track_frame("r81", frame_bits(8'h81, 1'b0, 1'b0), frame_len(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
